// File: rtl/riscv_pc_unit.sv
// Purpose: architectural PC register, next-PC select, misaligned-target trap, halt control, retire counter.
// Latency: PC/PCPlus4/PCTarget are combinational from the PC register; state updates land on the next i_clk edge.
// Backpressure: i_stall freezes PC, counter and state; HALT and TRAP suppress fetch until resume/trap-clear.
module riscv_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_PCSrc,
  input  logic [31:0]      i_ImmExt,
  input  logic [31:0]      i_ALUResult,
  input  logic             i_stall,
  input  logic             i_halt_req,
  input  logic             i_resume,
  input  logic             i_trap_clr,
  output logic [31:0]      o_PC,
  output logic [31:0]      o_PCPlus4,
  output logic [31:0]      o_PCTarget,
  output logic             o_fetch_valid,
  output logic             o_trap,
  output logic [31:0]      o_trap_epc,
  output logic [31:0]      o_trap_tval,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      tval_q, tval_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] nextpc;
  logic        misalign;

  // Candidate next PC; JALR targets always have bit 0 cleared, odd branch targets still count as misaligned.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    pc_target = pc_q + i_ImmExt;
    nextpc    = pc_plus4;
    unique case (i_PCSrc)
      2'b00:   nextpc = pc_plus4;
      2'b01:   nextpc = pc_target;
      default: nextpc = {i_ALUResult[31:1], 1'b0};
    endcase
    misalign = nextpc[1] | ((i_PCSrc == 2'b01) & nextpc[0]);
  end

  // Next-state: stall beats trap, trap beats retire/halt; HALT and TRAP only listen to their exit input.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    instret_d = instret_q;
    unique case (state_q)
      ST_RUN: begin
        if (i_stall) begin
          state_d = ST_RUN;
        end else if (misalign) begin
          epc_d   = pc_q;
          tval_d  = nextpc;
          state_d = ST_TRAP;
        end else begin
          pc_d      = nextpc;
          instret_d = instret_q + CNT_ONE;
          if (i_halt_req) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (i_resume) begin
          state_d = ST_RUN;
        end
      end
      ST_TRAP: begin
        if (i_trap_clr) begin
          pc_d    = TRAP_PC;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers; reset takes effect immediately, independent of the clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      epc_q     <= 32'd0;
      tval_q    <= 32'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      instret_q <= instret_d;
    end
  end

  assign o_PC          = pc_q;
  assign o_PCPlus4     = pc_plus4;
  assign o_PCTarget    = pc_target;
  assign o_fetch_valid = (state_q == ST_RUN);
  assign o_halted      = (state_q == ST_HALT);
  assign o_trap        = (state_q == ST_TRAP);
  assign o_trap_epc    = epc_q;
  assign o_trap_tval   = tval_q;
  assign o_instret     = instret_q;

endmodule
